// File: rtl/pe_job_sequencer.sv
// Job sequencer for a 16-lane combinational PE dot-product unit: registers chunk
// operands onto the PE buses, accumulates each chunk's PE result, returns the job total.
module pe_job_sequencer #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   chunk_cnt,
  input  logic               abort,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_i,
  input  logic [127:0]       in_w,
  output logic [127:0]       pe_i,
  output logic [127:0]       pe_w,
  input  logic [15:0]        pe_sum,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_acc,
  output logic               out_ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   remaining;
  logic               add_pending;
  logic [ACC_W-1:0]   acc;
  logic               ovf;
  logic               xfer;
  logic               job_abort;
  logic [ACC_W:0]     sum_wide;

  // abort suppresses the handshake and the result in the very cycle it is asserted
  assign job_abort = abort && (state != IDLE);
  assign busy      = (state != IDLE);
  assign in_ready  = (state == RUN) && !abort;
  assign out_valid = (state == DONE) && !abort;
  assign xfer      = in_valid && in_ready;
  assign out_acc   = acc;
  assign out_ovf   = ovf;

  // one extra bit catches the carry-out of each chunk add
  assign sum_wide  = {1'b0, acc} + {{(ACC_W + 1 - 16){1'b0}}, pe_sum};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (chunk_cnt == '0) ? DONE : RUN;
      RUN:     if (xfer && remaining == CNT_W'(1)) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (job_abort) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      remaining   <= '0;
      add_pending <= 1'b0;
      acc         <= '0;
      ovf         <= 1'b0;
      pe_i        <= '0;
      pe_w        <= '0;
    end else begin
      state       <= state_next;
      add_pending <= xfer;
      if (xfer) begin
        pe_i      <= in_i;
        pe_w      <= in_w;
        remaining <= remaining - CNT_W'(1);
      end
      // pe_sum reflects the operands registered on the previous transfer
      if (add_pending && !job_abort) begin
        acc <= sum_wide[ACC_W-1:0];
        if (sum_wide[ACC_W]) ovf <= 1'b1;
      end
      if (state == IDLE && start) begin
        remaining <= chunk_cnt;
        acc       <= '0;
        ovf       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_job_sequencer.sv
// Self-checking bench: a 24-bit and a 16-bit accumulator instance run in lockstep
// against a job-level model (sum of chunk dot products, wrap and carry from the total).
module tb_pe_job_sequencer;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    chunk_cnt = '0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [127:0]  in_i = '0;
  logic [127:0]  in_w = '0;
  logic          out_ready = 1'b0;

  logic          busy, in_ready, out_valid, out_ovf;
  logic [127:0]  pe_i, pe_w;
  logic [15:0]   pe_sum;
  logic [23:0]   out_acc;

  logic          busy16, in_ready16, out_valid16, out_ovf16;
  logic [127:0]  pe_i16, pe_w16;
  logic [15:0]   pe_sum16;
  logic [15:0]   out_acc16;

  int checks = 0;
  int errors = 0;

  logic [127:0] ci [0:7];
  logic [127:0] cw [0:7];

  always #5 clk = ~clk;

  function automatic logic [15:0] dot(input logic [127:0] a, input logic [127:0] b);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < 16; k++) s += a[8*k +: 8] * b[8*k +: 8];
    return s[15:0];
  endfunction

  assign pe_sum   = dot(pe_i, pe_w);
  assign pe_sum16 = dot(pe_i16, pe_w16);

  pe_job_sequencer #(.ACC_W(24), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chunk_cnt(chunk_cnt), .abort(abort),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_w(in_w),
    .pe_i(pe_i), .pe_w(pe_w), .pe_sum(pe_sum), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf)
  );

  pe_job_sequencer #(.ACC_W(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .chunk_cnt(chunk_cnt), .abort(abort),
    .busy(busy16), .in_valid(in_valid), .in_ready(in_ready16), .in_i(in_i), .in_w(in_w),
    .pe_i(pe_i16), .pe_w(pe_w16), .pe_sum(pe_sum16), .out_valid(out_valid16),
    .out_ready(out_ready), .out_acc(out_acc16), .out_ovf(out_ovf16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic fill(input int k, input logic [7:0] iv, input logic [7:0] wv);
    ci[k] = {16{iv}};
    cw[k] = {16{wv}};
  endtask

  // gap_mode: 0 = in_valid held high, 1 = toggling 1/0, 2 = random
  task automatic do_job(input int cnt, input int gap_mode, input int ready_delay);
    longint total;
    logic [127:0] exp24, exp16;
    logic eovf24, eovf16;
    int idx, budget;
    logic v, xf, toggle;
    total = 0;
    for (int k = 0; k < cnt; k++) total += longint'(dot(ci[k], cw[k]));
    exp24  = 128'(total % (64'd1 << 24));
    exp16  = 128'(total % (64'd1 << 16));
    eovf24 = (total >= (64'd1 << 24));
    eovf16 = (total >= (64'd1 << 16));

    start = 1'b1;
    chunk_cnt = 8'(cnt);
    tick();
    start = 1'b0;
    chunk_cnt = 8'($urandom_range(0, 255));
    check("busy_after_start", busy, 1'b1);

    if (cnt > 0) begin
      check("in_ready_run", in_ready, 1'b1);
      idx = 0;
      budget = 0;
      toggle = 1'b1;
      while (idx < cnt && budget < 200) begin
        case (gap_mode)
          0:       v = 1'b1;
          1:       v = toggle;
          default: v = 1'($urandom_range(0, 1));
        endcase
        toggle = !toggle;
        in_valid = v;
        in_i = v ? ci[idx] : rnd128();
        in_w = v ? cw[idx] : rnd128();
        xf = v && in_ready;
        tick();
        budget++;
        if (xf) begin
          check("pe_i_reg", pe_i, ci[idx]);
          idx++;
        end
      end
      in_valid = 1'b0;
      check("xfer_count", idx, cnt);
      check("in_ready_drain", in_ready, 1'b0);
      check("out_valid_drain", out_valid, 1'b0);
      tick();
    end

    check("out_valid_done", out_valid, 1'b1);
    check("in_ready_done", in_ready, 1'b0);
    check("out_acc24", out_acc, exp24);
    check("out_ovf24", out_ovf, eovf24);
    check("out_acc16", out_acc16, exp16);
    check("out_ovf16", out_ovf16, eovf16);

    out_ready = 1'b0;
    start = 1'b1;
    repeat (ready_delay) tick();
    check("out_valid_held", out_valid, 1'b1);
    check("out_acc_held", out_acc, exp24);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    check("out_valid_clear", out_valid, 1'b0);
    check("busy_idle", busy, 1'b0);
    tick();
    check("start_in_done_ignored", busy, 1'b0);
    $display("job cnt=%0d mode=%0d acc24=%0h acc16=%0h ovf16=%0b", cnt, gap_mode, out_acc, out_acc16, out_ovf16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_ovf", out_ovf, 1'b0);
    check("rst_out_acc", out_acc, 24'd0);
    check("rst_pe_i", pe_i, 128'd0);
    check("rst_pe_w", pe_w, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single chunk, I=1 W=2
    fill(0, 8'd1, 8'd2);
    do_job(1, 0, 0);

    // three chunks with toggling in_valid
    fill(0, 8'd1, 8'd1);
    fill(1, 8'd2, 8'd3);
    fill(2, 8'd0, 8'd9);
    do_job(3, 1, 1);

    // empty job, result held while out_ready is low
    do_job(0, 0, 5);

    // 16-bit accumulator wraps
    fill(0, 8'd255, 8'd255);
    fill(1, 8'd255, 8'd255);
    do_job(2, 0, 0);

    // abort after the second of four transfers
    for (int k = 0; k < 4; k++) begin
      ci[k] = rnd128();
      cw[k] = rnd128();
    end
    start = 1'b1;
    chunk_cnt = 8'd4;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_i = ci[k];
      in_w = cw[k];
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_in_ready", in_ready, 1'b0);
    check("abort_out_valid", out_valid, 1'b0);
    repeat (3) tick();
    check("abort_no_result", out_valid, 1'b0);
    $display("abort after 2 transfers busy=%0b out_valid=%0b", busy, out_valid);
    fill(0, 8'd1, 8'd1);
    do_job(1, 0, 0);

    // randomized jobs
    for (int j = 0; j < 10; j++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        ci[k] = rnd128();
        cw[k] = rnd128();
      end
      do_job(n, 2, $urandom_range(0, 3));
    end

    // asynchronous reset in the middle of a job
    fill(0, 8'd3, 8'd4);
    fill(1, 8'd5, 8'd6);
    start = 1'b1;
    chunk_cnt = 8'd3;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_i = ci[0];
    in_w = cw[0];
    tick();
    in_i = ci[1];
    in_w = cw[1];
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_in_ready", in_ready, 1'b0);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_pe_i", pe_i, 128'd0);
    check("arst_out_acc", out_acc, 24'd0);
    $display("async reset mid-run busy=%0b in_ready=%0b", busy, in_ready);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_idle_after", busy, 1'b0);
    check("arst_no_result", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
